// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: muldivop opcodes (also used by
// the E-stage decoder) and the IDLE/RUN state encoding.
package muldiv_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_launch_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: result is computed at launch, held pending,
// and committed to HI/LO after a fixed MULT_CYCLES/DIV_CYCLES busy period.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  muldivop,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] hi_pend, lo_pend;
    logic        wr_pend;
    logic        launch;

    logic signed [63:0] a_s, b_s, d_s, prod_s, quot_s, rem_s;
    logic        [63:0] a_u, b_u, d_u, prod_u, quot_u, rem_u;
    logic        [63:0] res;
    logic               div_zero;

    assign launch   = (state == ST_IDLE) && start && is_launch_op(muldivop);
    assign busy     = (state == ST_RUN);
    assign div_zero = (src_b == 32'd0);

    // The divisor is forced to 1 when zero so the divider never sees x/0;
    // that result is discarded via wr_pend anyway.
    always_comb begin
        a_s    = {{32{src_a[31]}}, src_a};
        b_s    = {{32{src_b[31]}}, src_b};
        a_u    = {32'd0, src_a};
        b_u    = {32'd0, src_b};
        d_s    = div_zero ? 64'sd1 : b_s;
        d_u    = div_zero ? 64'd1  : b_u;
        prod_s = a_s * b_s;
        prod_u = a_u * b_u;
        quot_s = a_s / d_s;
        rem_s  = a_s % d_s;
        quot_u = a_u / d_u;
        rem_u  = a_u % d_u;
        res    = 64'd0;
        case (muldivop)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = {rem_s[31:0], quot_s[31:0]};
            OP_DIVU:  res = {rem_u[31:0], quot_u[31:0]};
            default:  res = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == 4'd0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // MTHI/MTLO write in IDLE regardless of start; in RUN they are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
            wr_pend <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (launch) begin
                hi_pend <= res[63:32];
                lo_pend <= res[31:0];
                wr_pend <= !(div_zero && (muldivop == OP_DIV || muldivop == OP_DIVU));
                cnt     <= (muldivop == OP_MULT || muldivop == OP_MULTU)
                           ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
            end else if (muldivop == OP_MTHI) begin
                hi <= src_a;
            end else if (muldivop == OP_MTLO) begin
                lo <= src_a;
            end
        end else begin
            if (cnt == 4'd0) begin
                if (wr_pend) begin
                    hi <= hi_pend;
                    lo <= lo_pend;
                end
                wr_pend <= 1'b0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule
